// File: rtl/msgpass_rd_window_ctrl_pkg.sv
// Shared configuration for the message-pass read-window sequencer:
// state encoding, window depth, counter widths and memShare DRC defaults.
package msgpass_rd_window_ctrl_pkg;

    localparam int RDWIN_MAX_RD = 32;
    localparam int RDWIN_LEN_W  = $clog2(RDWIN_MAX_RD + 1);
    localparam int RDWIN_IDX_W  = $clog2(RDWIN_MAX_RD);

    // Mirrors of the memShare configuration constants
    localparam int MEMSHARE_DRC_NUM = 2;
    localparam int MEMSHARE_DRC1    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_END  = 2'd2
    } rdwin_state_t;

endpackage

// File: rtl/msgpass_rd_window_ctrl_if.sv
// Request/response bundle between a window requester (master) and the
// read-window sequencer (slave).
interface msgpass_rd_window_ctrl_if
    import msgpass_rd_window_ctrl_pkg::*;
#(
    parameter int MAX_RD  = RDWIN_MAX_RD,
    parameter int DRC_NUM = MEMSHARE_DRC_NUM
);
    localparam int LEN_W = $clog2(MAX_RD + 1);
    localparam int IDX_W = $clog2(MAX_RD);

    logic               start_i;
    logic [LEN_W-1:0]   rd_len_i;
    logic [MAX_RD-1:0]  drc_mask_i;
    logic               abort_i;

    logic               ready_o;
    logic               buffer_read_begin_o;
    logic               buffer_read_end_o;
    logic [DRC_NUM-1:0] is_drc_o;
    logic               rd_valid_o;
    logic [IDX_W-1:0]   rd_idx_o;
    logic               done_o;
    logic               aborted_o;
    logic               start_drop_o;

    modport master (
        output start_i, rd_len_i, drc_mask_i, abort_i,
        input  ready_o, buffer_read_begin_o, buffer_read_end_o, is_drc_o,
               rd_valid_o, rd_idx_o, done_o, aborted_o, start_drop_o
    );

    modport slave (
        input  start_i, rd_len_i, drc_mask_i, abort_i,
        output ready_o, buffer_read_begin_o, buffer_read_end_o, is_drc_o,
               rd_valid_o, rd_idx_o, done_o, aborted_o, start_drop_o
    );

endinterface

// File: rtl/msgpass_rd_idx_cnt.sv
// Read index counter: loads a saturated window length, steps the index and
// flags the terminal (last) read of the window.
module msgpass_rd_idx_cnt
    import msgpass_rd_window_ctrl_pkg::*;
#(
    parameter int MAX_RD = RDWIN_MAX_RD,
    localparam int LEN_W = $clog2(MAX_RD + 1),
    localparam int IDX_W = $clog2(MAX_RD)
)(
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             step,
    output logic [IDX_W-1:0] idx_next,
    output logic             last
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_sat;
    logic [IDX_W-1:0] idx_q;

    always_comb begin
        len_sat  = (len > LEN_W'(MAX_RD)) ? LEN_W'(MAX_RD) : len;
        idx_next = idx_q;
        if (load) begin
            idx_next = '0;
        end else if (step) begin
            idx_next = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            idx_q <= '0;
        end else begin
            if (load) begin
                len_q <= len_sat;
            end
            idx_q <= idx_next;
        end
    end

    // Only meaningful while a window is active (len_q >= 1)
    assign last = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

endmodule

// File: rtl/msgpass_rd_window_ctrl.sv
// Read-window sequencer feeding the message-pass buffer address generator.
// Optional MSGPASS_RDWIN_BACK2BACK_EN lets a new window start in the END cycle.
module msgpass_rd_window_ctrl
    import msgpass_rd_window_ctrl_pkg::*;
#(
    parameter int MAX_RD   = RDWIN_MAX_RD,
    parameter int DRC_NUM  = MEMSHARE_DRC_NUM,
    parameter int DRC1_IDX = MEMSHARE_DRC1
)(
    input  logic                   sys_clk,
    input  logic                   rst,
    msgpass_rd_window_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_RD);

`ifdef MSGPASS_RDWIN_BACK2BACK_EN
    localparam bit BACK2BACK = 1'b1;
`else
    localparam bit BACK2BACK = 1'b0;
`endif

    rdwin_state_t       state, state_next;
    logic [MAX_RD-1:0]  mask_q, mask_next;
    logic [IDX_W-1:0]   idx_next;
    logic               can_start, load, step, last;
    logic               ready_n, end_n, valid_n, done_n, aborted_n, drop_n;
    logic [DRC_NUM-1:0] drc_n;

    msgpass_rd_idx_cnt #(.MAX_RD(MAX_RD)) u_idx_cnt (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (load),
        .len      (bus.rd_len_i),
        .step     (step),
        .idx_next (idx_next),
        .last     (last)
    );

    // Outputs are computed for the next cycle so every port is a flop
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        end_n      = 1'b0;
        done_n     = 1'b0;
        aborted_n  = 1'b0;
        can_start  = (state == ST_IDLE) || (BACK2BACK && (state == ST_END));
        drop_n     = bus.start_i && !can_start;

        case (state)
            ST_READ: begin
                if (bus.abort_i || last) begin
                    state_next = ST_END;
                    end_n      = 1'b1;
                    done_n     = 1'b1;
                    aborted_n  = bus.abort_i;
                end else begin
                    step = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (bus.start_i && can_start) begin
                    if (bus.rd_len_i != '0) begin
                        state_next = ST_READ;
                        load       = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
        endcase

        mask_next       = load ? bus.drc_mask_i : mask_q;
        valid_n         = (state_next == ST_READ);
        ready_n         = (state_next == ST_IDLE) || (BACK2BACK && (state_next == ST_END));
        drc_n           = '0;
        drc_n[DRC1_IDX] = valid_n && mask_next[idx_next];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state                   <= ST_IDLE;
            mask_q                  <= '0;
            bus.ready_o             <= 1'b1;
            bus.buffer_read_begin_o <= 1'b0;
            bus.buffer_read_end_o   <= 1'b0;
            bus.is_drc_o            <= '0;
            bus.rd_valid_o          <= 1'b0;
            bus.rd_idx_o            <= '0;
            bus.done_o              <= 1'b0;
            bus.aborted_o           <= 1'b0;
            bus.start_drop_o        <= 1'b0;
        end else begin
            state                   <= state_next;
            mask_q                  <= mask_next;
            bus.ready_o             <= ready_n;
            bus.buffer_read_begin_o <= load;
            bus.buffer_read_end_o   <= end_n;
            bus.is_drc_o            <= drc_n;
            bus.rd_valid_o          <= valid_n;
            bus.rd_idx_o            <= valid_n ? idx_next : '0;
            bus.done_o              <= done_n;
            bus.aborted_o           <= aborted_n;
            bus.start_drop_o        <= drop_n;
        end
    end

endmodule

// File: tb/tb_msgpass_rd_window_ctrl.sv
// Self-checking bench for msgpass_rd_window_ctrl: directed window table,
// hand-written reset/back-to-back sequences and random windows vs. a window model.
module tb_msgpass_rd_window_ctrl;
    import msgpass_rd_window_ctrl_pkg::*;

    localparam int MAX_RD   = RDWIN_MAX_RD;
    localparam int DRC_NUM  = MEMSHARE_DRC_NUM;
    localparam int DRC1_IDX = MEMSHARE_DRC1;
    localparam int LEN_W    = RDWIN_LEN_W;
    localparam int IDX_W    = RDWIN_IDX_W;

`ifdef MSGPASS_RDWIN_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef struct packed {
        logic               ready;
        logic               begin_p;
        logic               end_p;
        logic [DRC_NUM-1:0] drc;
        logic               valid;
        logic [IDX_W-1:0]   idx;
        logic               done;
        logic               aborted;
        logic               drop;
    } obs_t;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] mask;
        int          abort_at;
        int          drop_at;
        int          exp_reads;
        bit          exp_aborted;
    } vec_t;

    logic sys_clk;
    logic rst;
    int   n_vec;
    int   n_err;

    msgpass_rd_window_ctrl_if #(.MAX_RD(MAX_RD), .DRC_NUM(DRC_NUM)) bus ();

    msgpass_rd_window_ctrl #(
        .MAX_RD   (MAX_RD),
        .DRC_NUM  (DRC_NUM),
        .DRC1_IDX (DRC1_IDX)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ready   = bus.ready_o;
        o.begin_p = bus.buffer_read_begin_o;
        o.end_p   = bus.buffer_read_end_o;
        o.drc     = bus.is_drc_o;
        o.valid   = bus.rd_valid_o;
        o.idx     = bus.rd_idx_o;
        o.done    = bus.done_o;
        o.aborted = bus.aborted_o;
        o.drop    = bus.start_drop_o;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Window model: cycle c (1 = first cycle after the start edge) of a window
    function automatic obs_t expect_cycle(int n, logic [31:0] mask, int abort_at, int c, bit drop_exp);
        obs_t e = '0;
        int nn = (n > MAX_RD) ? MAX_RD : n;
        int last_idx;
        e.drop = drop_exp;
        if (nn == 0) begin
            e.ready = 1'b1;
            e.done  = (c == 1);
            return e;
        end
        last_idx = (abort_at >= 0 && abort_at < nn) ? abort_at : nn - 1;
        if (c <= last_idx + 1) begin
            e.valid         = 1'b1;
            e.idx           = IDX_W'(c - 1);
            e.begin_p       = (c == 1);
            e.drc[DRC1_IDX] = mask[c - 1];
        end else if (c == last_idx + 2) begin
            e.end_p   = 1'b1;
            e.done    = 1'b1;
            e.aborted = (abort_at >= 0 && abort_at < nn);
            e.ready   = B2B;
        end else begin
            e.ready = 1'b1;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got rdy/beg/end/drc/val/idx/done/abt/drop=%b expected %b",
                     name, got, exp);
        end
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issue one window from IDLE and check every cycle until back in IDLE
    task automatic run_window(input string name, input int n, input logic [31:0] mask,
                              input int abort_at, input int drop_at,
                              output int reads, output bit saw_abort);
        int   nn;
        int   last_idx;
        int   total;
        obs_t got;
        obs_t exp;
        nn        = (n > MAX_RD) ? MAX_RD : n;
        last_idx  = (nn == 0) ? -1 : ((abort_at >= 0 && abort_at < nn) ? abort_at : nn - 1);
        total     = (nn == 0) ? 2 : last_idx + 3;
        reads     = 0;
        saw_abort = 1'b0;
        bus.start_i    = 1'b1;
        bus.rd_len_i   = LEN_W'(n);
        bus.drc_mask_i = mask;
        for (int c = 1; c <= total; c++) begin
            tick();
            got = sample();
            exp = expect_cycle(n, mask, abort_at, c, (drop_at > 0) && (c == drop_at + 1));
            check_output($sformatf("%s c%0d", name, c), got, exp);
            reads += int'(got.valid);
            if (got.aborted) saw_abort = 1'b1;
            bus.start_i    = (drop_at > 0) && (c == drop_at);
            bus.rd_len_i   = LEN_W'($urandom);
            bus.drc_mask_i = $urandom;
            if (c <= last_idx + 1) bus.abort_i = (c - 1 == abort_at);
            else                   bus.abort_i = 1'($urandom_range(0, 1));
        end
        bus.start_i = 1'b0;
    endtask

    task automatic apply_stimulus();
        vec_t        vecs[8];
        int          reads;
        bit          saw_abort;
        int          n;
        int          nn;
        int          abort_at;
        int          drop_at;
        int          last_idx;
        logic [31:0] mask;
        obs_t        exp;

        vecs[0] = '{"n4_mask0101",   4,  32'h0000_0005, -1, 0,  4,  1'b0};
        vecs[1] = '{"n1",            1,  32'h0000_0001, -1, 0,  1,  1'b0};
        vecs[2] = '{"n0",            0,  32'hFFFF_FFFF, -1, 0,  0,  1'b0};
        vecs[3] = '{"n8_abort2",     8,  32'h0000_00A5,  2, 0,  3,  1'b1};
        vecs[4] = '{"n5_dropstart",  5,  32'h0000_001F, -1, 2,  5,  1'b0};
        vecs[5] = '{"n40_saturate", 40,  32'hDEAD_BEEF, -1, 0, 32,  1'b0};
        vecs[6] = '{"n3_abortlast",  3,  32'h0000_0002,  2, 0,  3,  1'b1};
        vecs[7] = '{"n32_drop10",   32,  32'h8000_0001, -1, 10, 32, 1'b0};

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].name, vecs[i].n, vecs[i].mask, vecs[i].abort_at,
                       vecs[i].drop_at, reads, saw_abort);
            check_count({vecs[i].name, " reads"}, reads, vecs[i].exp_reads);
            check_count({vecs[i].name, " aborted"}, int'(saw_abort), int'(vecs[i].exp_aborted));
        end

        // Reset in the middle of a 6-read window: outputs clear at once, no end pulse
        bus.abort_i    = 1'b0;
        bus.start_i    = 1'b1;
        bus.rd_len_i   = LEN_W'(6);
        bus.drc_mask_i = 32'h0000_0008;
        tick();
        bus.start_i = 1'b0;
        repeat (3) tick();
        check_output("rst_pre_idx3", sample(), expect_cycle(6, 32'h8, -1, 4, 1'b0));
        rst = 1'b1;
        #1;
        check_output("rst_mid_async", sample(), idle_obs());
        @(negedge sys_clk);
        rst = 1'b0;
        tick();
        check_output("rst_after1", sample(), idle_obs());
        tick();
        check_output("rst_after2", sample(), idle_obs());

        // Start presented in the END cycle of a 2-read window
        bus.start_i    = 1'b1;
        bus.rd_len_i   = LEN_W'(2);
        bus.drc_mask_i = 32'h0000_0002;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        check_output("end_cycle", sample(), expect_cycle(2, 32'h2, -1, 3, 1'b0));
        bus.start_i    = 1'b1;
        bus.rd_len_i   = LEN_W'(3);
        bus.drc_mask_i = 32'h0000_0003;
        tick();
        bus.start_i = 1'b0;
`ifdef MSGPASS_RDWIN_BACK2BACK_EN
        for (int c = 1; c <= 5; c++) begin
            check_output($sformatf("b2b c%0d", c), sample(), expect_cycle(3, 32'h3, -1, c, 1'b0));
            tick();
        end
`else
        exp      = idle_obs();
        exp.drop = 1'b1;
        check_output("end_start_dropped", sample(), exp);
        tick();
        check_output("end_gap_idle", sample(), idle_obs());
`endif

        // Random windows against the window model
        for (int i = 0; i < 40; i++) begin
            n        = int'($urandom_range(0, MAX_RD + 3));
            mask     = $urandom;
            nn       = (n > MAX_RD) ? MAX_RD : n;
            abort_at = -1;
            drop_at  = 0;
            if (nn > 0 && $urandom_range(0, 1) == 1) abort_at = int'($urandom_range(0, nn - 1));
            last_idx = (abort_at >= 0) ? abort_at : nn - 1;
            if (nn > 0 && $urandom_range(0, 2) == 0) drop_at = int'($urandom_range(1, last_idx + 1));
            run_window($sformatf("rnd%0d_n%0d", i, n), n, mask, abort_at, drop_at, reads, saw_abort);
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.rd_len_i   = '0;
        bus.drc_mask_i = '0;
        bus.abort_i    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_output("reset_state", sample(), idle_obs());
        @(negedge sys_clk);
        rst = 1'b0;
        bus.abort_i = 1'b1;
        tick();
        check_output("idle_abort_ignored", sample(), idle_obs());
        bus.abort_i = 1'b0;

        apply_stimulus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
